dm_access_ctrl: RTL



---
 rtl/dm_access_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dm_access_ctrl.sv
// Data-memory responder: accepts a PS read/write, waits WAIT_STATES cycles, then commits or returns data.
// Optional range check on upper address bits is enabled by defining DM_RANGE_CHK_EN.
module dm_access_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps_dm_en,
  input  logic              ps_dm_wrt_en,
  input  logic [15:0]       dg_dm_add,
  input  logic [DATA_W-1:0] bc_dt,
  output logic [DATA_W-1:0] dm_bc_dt,
  output logic              dm_ps_ack,
  output logic              dm_ps_rdy,
  output logic              dm_ps_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t              state_r, state_nx;
  logic [3:0]          cnt_r, cnt_nx;
  logic [15:0]         addr_r;
  logic                wrt_r;
  logic [DATA_W-1:0]   data_r;
  logic                accept_s;
  logic                fire_s;
  logic [15:0]         op_addr_s;
  logic                op_wrt_s;
  logic [DATA_W-1:0]   op_data_s;
  logic                bad_s;
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

  // Next-state and wait-counter logic
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      S_IDLE, S_RESP: begin
        if (ps_dm_en) begin
          accept_s = 1'b1;
          state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          cnt_nx   = CNT_INIT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx = S_RESP;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Select the access that completes at this edge; with no wait states it is the live request
  always_comb begin
    fire_s    = 1'b0;
    op_addr_s = addr_r;
    op_wrt_s  = wrt_r;
    op_data_s = data_r;
    if (WAIT_STATES == 0) begin
      fire_s    = accept_s;
      op_addr_s = dg_dm_add;
      op_wrt_s  = ps_dm_wrt_en;
      op_data_s = bc_dt;
    end else begin
      fire_s = (state_r == S_WAIT) && (cnt_r == 4'd0);
    end
    if (rst) begin
      fire_s = 1'b0;
    end else begin
      fire_s = fire_s;
    end
  end

`ifdef DM_RANGE_CHK_EN
  assign bad_s = |op_addr_s[15:ADDR_W];
`else
  logic unused_upper_s;
  assign bad_s          = 1'b0;
  assign unused_upper_s = ^op_addr_s[15:ADDR_W];
`endif

  // Control state, request latch and registered responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= 4'd0;
      addr_r    <= 16'd0;
      wrt_r     <= 1'b0;
      data_r    <= '0;
      dm_bc_dt  <= '0;
      dm_ps_ack <= 1'b0;
      dm_ps_rdy <= 1'b1;
      dm_ps_err <= 1'b0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      dm_ps_rdy <= (state_nx == S_IDLE) || (state_nx == S_RESP);
      dm_ps_ack <= fire_s;
      dm_ps_err <= fire_s & bad_s;
      if (accept_s) begin
        addr_r <= dg_dm_add;
        wrt_r  <= ps_dm_wrt_en;
        data_r <= bc_dt;
      end
      if (fire_s && !op_wrt_s) begin
        dm_bc_dt <= bad_s ? '0 : mem[op_addr_s[ADDR_W-1:0]];
      end
    end
  end

  // Storage array, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (fire_s && op_wrt_s && !bad_s) begin
      mem[op_addr_s[ADDR_W-1:0]] <= op_data_s;
    end
  end

endmodule
